mshr_repair_controller: RTL and testbench
=========================================

MSHR_REPAIR_CONTROLLER -- requirements
Module: mshr_repair_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, meaning the WAIT_RESP cycle limit (used only under REQ-032).
REQ-002 SHALL have these ports, one per line; name, direction, width, meaning:
- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  pipeline flush.
- repair_req_i  in  1  repair request from the MSHR.
- repair_req_addr_i  in  32  request address.
- repair_req_data_i  in  32  store data.
- repair_req_rob_idx_i  in  ROB_IDX_W  ROB index of the missing op.
- repair_is_store_i  in  1  1 = store, 0 = load.
- repair_ack_o  out  1  request accepted this cycle.
- repair_complete_o  out  1  one-cycle pulse; the MSHR entry is retired.
- mem_req_valid_o  out  1  memory request valid.
- mem_req_ready_i  in  1  memory accepts the request.
- mem_req_addr_o  out  32  address sent to memory.
- mem_req_wdata_o  out  32  write data sent to memory.
- mem_req_we_o  out  1  write enable.
- mem_resp_valid_i  in  1  memory response or write acknowledge.
- mem_resp_rdata_i  in  32  read data.
- wb_valid_o  out  1  load writeback valid.
- wb_ready_i  in  1  writeback port accepts.
- wb_data_o  out  32  load data.
- wb_rob_idx_o  out  ROB_IDX_W  ROB index for the writeback.
- busy_o  out  1  state is not IDLE.
- timeout_o  out  1  timeout pulse (only under REQ-032).

Function
REQ-010 SHALL implement the FSM states IDLE, ISSUE, WAIT_RESP, WRITEBACK, DRAIN, DONE.
REQ-011 SHALL drive repair_ack_o = (state==IDLE) && repair_req_i && !flush_i, combinationally.
REQ-012 On ack, SHALL latch addr, data, rob_idx and is_store, then go to ISSUE.
REQ-013 In ISSUE, SHALL hold mem_req_valid_o=1 with the latched fields; mem_req_we_o = is_store.
REQ-014 In ISSUE, on mem_req_ready_i, SHALL go to WAIT_RESP; valid SHALL NOT drop before ready.
REQ-015 In WAIT_RESP, on mem_resp_valid_i, SHALL capture rdata.
- Load: go to WRITEBACK.
- Store: go to DONE; rdata ignored.
REQ-016 In WRITEBACK, SHALL hold wb_valid_o=1 with the captured data and rob_idx; on wb_ready_i, go to DONE.
REQ-017 In DONE, SHALL assert repair_complete_o for exactly one cycle, then go to IDLE.
REQ-018 Minimum latency SHALL be: ack to complete = 4 cycles for a store, 5 for a load, with ready/resp/wb_ready immediate.
REQ-019 flush_i in ISSUE SHALL go straight to DONE (no memory request issued), whether or not mem_req_ready_i is high that cycle.
REQ-020 flush_i in WAIT_RESP SHALL go to DRAIN, or directly to DONE if mem_resp_valid_i is high that cycle.
REQ-021 DRAIN SHALL wait for mem_resp_valid_i, discard it, then go to DONE.
REQ-022 flush_i in WRITEBACK SHALL drop wb_valid_o and go to DONE.
REQ-023 The completion pulse SHALL still fire after a flush, so the MSHR repairing state clears.
REQ-024 mem_resp_valid_i in IDLE, ISSUE or DONE SHALL be ignored.
REQ-025 Exactly one transaction SHALL be outstanding at any time; no new ack before DONE.
REQ-026 flush_i in IDLE or DONE SHALL have no effect, except blocking ack.

Reset
REQ-027 Reset SHALL be asynchronous on the falling edge of rst_ni, synchronously deasserted.
REQ-028 During reset, state SHALL be IDLE.
REQ-029 During reset, every output SHALL be 0 and all latched fields and counters SHALL be cleared.
REQ-030 Reset mid-transaction SHALL abandon it without a completion pulse.

Configuration
REQ-031 Macro MSHR_REPAIR_TIMEOUT_EN SHALL select the timeout feature.
REQ-032 With the macro defined, a counter SHALL run in WAIT_RESP and DRAIN.
- When it reaches TIMEOUT_CYCLES: pulse timeout_o for one cycle, suppress writeback, go to DONE.
- The counter SHALL clear when the FSM leaves those states.
REQ-033 Without the macro, there SHALL be no counter; timeout_o SHALL be tied to 0 and WAIT_RESP/DRAIN SHALL wait indefinitely.

Structure
REQ-034 ROB_IDX_W = $clog2(ROB_ENTRIES) and the FSM state enum SHALL live in CORE_PKG.
REQ-035 The latched request SHALL be a packed struct in CORE_PKG.
REQ-036 The block SHALL be a single module with no sub-module; the timeout counter SHALL be inline.

Verification
REQ-037 Load, all ready: req addr=0x1000, rob=5; resp rdata=0xDEADBEEF.
- Required: wb_data_o=0xDEADBEEF and wb_rob_idx_o=5.
- Required: complete pulses 5 cycles after ack.
REQ-038 Store, ready delayed: store addr=0x2004, data=0x12345678; mem_req_ready_i low for 3 cycles.
- Required: valid and fields held stable.
- Required: we=1, no wb_valid_o, one complete pulse.
REQ-039 Flush in ISSUE or WAIT_RESP:
- Flush in ISSUE: no further mem_req_valid_o, one complete pulse.
- Flush in WAIT_RESP: DRAIN absorbs a response arriving 4 cycles later, wb_valid_o stays 0, then one complete pulse.
REQ-040 Back-to-back: two queued loads.
- Required: second ack only after the first complete.
- Required: no overlapping mem_req_valid_o.
REQ-041 Timeout with MSHR_REPAIR_TIMEOUT_EN and TIMEOUT_CYCLES=8: no response.
- Required: timeout_o pulses once, followed by one complete pulse.
- Required: a late response in IDLE is ignored.
REQ-042 Async reset asserted in WRITEBACK:
- Required: all outputs 0 immediately.
- Required: IDLE after release, no complete pulse.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types: ROB index width, the MSHR repair FSM states and the latched repair request.
package core_pkg;

   localparam int ROB_ENTRIES = 32;
   localparam int ROB_IDX_W   = $clog2(ROB_ENTRIES);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_RESP,
      WRITEBACK,
      DRAIN,
      DONE
   } repair_state_e;

   typedef struct packed {
      logic [31:0]          addr;
      logic [31:0]          data;
      logic [ROB_IDX_W-1:0] rob_idx;
      logic                 is_store;
   } repair_req_t;

endpackage

// File: rtl/mshr_repair_controller.sv
// Replays one missed load/store from the MSHR to memory and retires the entry with a completion pulse.
// Optional response timeout in WAIT_RESP/DRAIN is enabled by defining MSHR_REPAIR_TIMEOUT_EN.
module mshr_repair_controller
   import core_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 flush_i,
   input  logic                 repair_req_i,
   input  logic [31:0]          repair_req_addr_i,
   input  logic [31:0]          repair_req_data_i,
   input  logic [ROB_IDX_W-1:0] repair_req_rob_idx_i,
   input  logic                 repair_is_store_i,
   output logic                 repair_ack_o,
   output logic                 repair_complete_o,
   output logic                 mem_req_valid_o,
   input  logic                 mem_req_ready_i,
   output logic [31:0]          mem_req_addr_o,
   output logic [31:0]          mem_req_wdata_o,
   output logic                 mem_req_we_o,
   input  logic                 mem_resp_valid_i,
   input  logic [31:0]          mem_resp_rdata_i,
   output logic                 wb_valid_o,
   input  logic                 wb_ready_i,
   output logic [31:0]          wb_data_o,
   output logic [ROB_IDX_W-1:0] wb_rob_idx_o,
   output logic                 busy_o,
   output logic                 timeout_o
);

   repair_state_e r_state;
   repair_req_t   r_req;
   logic [31:0]   r_rdata;
   logic          r_complete;
   logic          w_timeout_fire;

   // Ack is gated by reset so every output reads 0 while rst_ni is low.
   assign repair_ack_o      = rst_ni && (r_state == IDLE) && repair_req_i && !flush_i;
   assign repair_complete_o = r_complete;
   assign busy_o            = (r_state != IDLE);

   // A flush withdraws the memory request and the writeback in the very cycle it arrives.
   assign mem_req_valid_o   = (r_state == ISSUE) && !flush_i;
   assign mem_req_we_o      = mem_req_valid_o && r_req.is_store;
   assign mem_req_addr_o    = r_req.addr;
   assign mem_req_wdata_o   = r_req.data;
   assign wb_valid_o        = (r_state == WRITEBACK) && !flush_i;
   assign wb_data_o         = r_rdata;
   assign wb_rob_idx_o      = r_req.rob_idx;

`ifdef MSHR_REPAIR_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] r_timer;
   logic          r_timeout;
   logic          w_in_wait;
   logic          w_timeout_hit;
   logic          w_leave;

   assign w_in_wait      = (r_state == WAIT_RESP) || (r_state == DRAIN);
   assign w_timeout_hit  = (r_timer >= TW'(TIMEOUT_CYCLES - 1));
   assign w_timeout_fire = !mem_resp_valid_i && w_timeout_hit &&
                           (((r_state == WAIT_RESP) && !flush_i) || (r_state == DRAIN));
   assign w_leave        = mem_resp_valid_i || w_timeout_fire;
   assign timeout_o      = r_timeout;

   // Counter spans WAIT_RESP and DRAIN together; it restarts only once the FSM leaves both.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_timer   <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_timeout_fire;
         r_timer   <= (w_in_wait && !w_leave) ? r_timer + 1'b1 : '0;
      end
   end
`else
   logic [31:0] w_unused_timeout;

   assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
   assign w_timeout_fire   = 1'b0;
   assign timeout_o        = 1'b0;
`endif

   // DONE lasts two cycles: the first arms the completion pulse, the second shows it and returns to IDLE.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= IDLE;
         r_req      <= '0;
         r_rdata    <= '0;
         r_complete <= 1'b0;
      end else begin
         r_complete <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (repair_ack_o) begin
                  r_req   <= '{addr:     repair_req_addr_i,
                               data:     repair_req_data_i,
                               rob_idx:  repair_req_rob_idx_i,
                               is_store: repair_is_store_i};
                  r_state <= ISSUE;
               end
            end
            ISSUE: begin
               if (flush_i) begin
                  r_state <= DONE;
               end else if (mem_req_ready_i) begin
                  r_state <= WAIT_RESP;
               end
            end
            WAIT_RESP: begin
               if (mem_resp_valid_i) begin
                  if (!r_req.is_store) begin
                     r_rdata <= mem_resp_rdata_i;
                  end
                  r_state <= (r_req.is_store || flush_i) ? DONE : WRITEBACK;
               end else if (flush_i) begin
                  r_state <= DRAIN;
               end else if (w_timeout_fire) begin
                  r_state <= DONE;
               end
            end
            WRITEBACK: begin
               if (flush_i || wb_ready_i) begin
                  r_state <= DONE;
               end
            end
            DRAIN: begin
               if (mem_resp_valid_i || w_timeout_fire) begin
                  r_state <= DONE;
               end
            end
            DONE: begin
               if (r_complete) begin
                  r_state <= IDLE;
               end else begin
                  r_complete <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mshr_repair_controller.sv
// Self-checking bench for mshr_repair_controller; covers the MSHR_REPAIR_TIMEOUT_EN build when that macro is defined.
module tb_mshr_repair_controller;
   import core_pkg::*;

   logic                 clk_i = 1'b0;
   logic                 rst_ni;
   logic                 flush_i;
   logic                 repair_req_i;
   logic [31:0]          repair_req_addr_i;
   logic [31:0]          repair_req_data_i;
   logic [ROB_IDX_W-1:0] repair_req_rob_idx_i;
   logic                 repair_is_store_i;
   logic                 repair_ack_o;
   logic                 repair_complete_o;
   logic                 mem_req_valid_o;
   logic                 mem_req_ready_i;
   logic [31:0]          mem_req_addr_o;
   logic [31:0]          mem_req_wdata_o;
   logic                 mem_req_we_o;
   logic                 mem_resp_valid_i;
   logic [31:0]          mem_resp_rdata_i;
   logic                 wb_valid_o;
   logic                 wb_ready_i;
   logic [31:0]          wb_data_o;
   logic [ROB_IDX_W-1:0] wb_rob_idx_o;
   logic                 busy_o;
   logic                 timeout_o;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk_i = ~clk_i;

   mshr_repair_controller #(.TIMEOUT_CYCLES(8)) dut (
      .clk_i                (clk_i),
      .rst_ni               (rst_ni),
      .flush_i              (flush_i),
      .repair_req_i         (repair_req_i),
      .repair_req_addr_i    (repair_req_addr_i),
      .repair_req_data_i    (repair_req_data_i),
      .repair_req_rob_idx_i (repair_req_rob_idx_i),
      .repair_is_store_i    (repair_is_store_i),
      .repair_ack_o         (repair_ack_o),
      .repair_complete_o    (repair_complete_o),
      .mem_req_valid_o      (mem_req_valid_o),
      .mem_req_ready_i      (mem_req_ready_i),
      .mem_req_addr_o       (mem_req_addr_o),
      .mem_req_wdata_o      (mem_req_wdata_o),
      .mem_req_we_o         (mem_req_we_o),
      .mem_resp_valid_i     (mem_resp_valid_i),
      .mem_resp_rdata_i     (mem_resp_rdata_i),
      .wb_valid_o           (wb_valid_o),
      .wb_ready_i           (wb_ready_i),
      .wb_data_o            (wb_data_o),
      .wb_rob_idx_o         (wb_rob_idx_o),
      .busy_o               (busy_o),
      .timeout_o            (timeout_o)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic req, input logic flush, input logic ready,
                                input logic resp, input logic wbReady);
      repair_req_i     = req;
      flush_i          = flush;
      mem_req_ready_i  = ready;
      mem_resp_valid_i = resp;
      wb_ready_i       = wbReady;
   endtask

   task automatic setRequest(input logic isStore, input logic [31:0] addr, input logic [31:0] data,
                             input logic [ROB_IDX_W-1:0] rob);
      repair_is_store_i    = isStore;
      repair_req_addr_i    = addr;
      repair_req_data_i    = data;
      repair_req_rob_idx_i = rob;
   endtask

   task automatic nextCycle();
      @(posedge clk_i);
      #1;
   endtask

   // Memory/writeback responder with fixed stall counts; the reference is the end-to-end
   // latency (4 for a store, 5 for a load, plus every stall cycle) and the request fields.
   task automatic runTxn(input logic isStore, input logic [31:0] addr, input logic [31:0] data,
                         input logic [ROB_IDX_W-1:0] rob, input logic [31:0] rdata,
                         input int rdyDly, input int respDly, input int wbDly, input bit keepReq);
      int  ackCyc = -1, compCyc = -1, vCnt = 0, wCnt = 0, waitCnt = 0;
      int  ackCnt = 0, compCnt = 0, toCnt = 0, expLat;
      bit  issued = 0, responded = 0, acked = 0;
      expLat = isStore ? 4 + rdyDly + respDly : 5 + rdyDly + respDly + wbDly;
      setRequest(isStore, addr, data, rob);
      repair_req_i = 1'b1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         bit realResp, junk;
         if (acked && !keepReq) repair_req_i = 1'b0;
         realResp         = issued && !responded && (waitCnt == respDly);
         junk             = mem_req_valid_o && ($urandom_range(0, 1) == 1);
         flush_i          = 1'b0;
         mem_req_ready_i  = mem_req_valid_o && (vCnt >= rdyDly);
         mem_resp_valid_i = realResp || junk;
         mem_resp_rdata_i = realResp ? rdata : $urandom;
         wb_ready_i       = wb_valid_o && (wCnt >= wbDly);
         @(negedge clk_i);
         if (repair_ack_o) begin
            ackCnt++;
            if (!acked) begin
               acked  = 1;
               ackCyc = cyc;
            end
         end
         if (mem_req_valid_o) begin
            checkOutput("req_addr", mem_req_addr_o, addr);
            checkOutput("req_wdata", mem_req_wdata_o, data);
            checkOutput("req_we", 32'(mem_req_we_o), 32'(isStore));
            vCnt++;
            if (mem_req_ready_i) begin
               issued  = 1;
               waitCnt = 0;
            end
         end else if (issued && !responded) begin
            if (realResp) responded = 1;
            else          waitCnt++;
         end
         if (wb_valid_o) begin
            checkOutput("wb_data", wb_data_o, rdata);
            checkOutput("wb_rob_idx", 32'(wb_rob_idx_o), 32'(rob));
            wCnt++;
         end
         if (repair_complete_o) begin
            compCnt++;
            if (compCyc < 0) compCyc = cyc;
         end
         if (timeout_o) toCnt++;
         nextCycle();
         if (compCyc >= 0 && (keepReq || cyc >= compCyc + 2)) break;
      end
      if (!keepReq) repair_req_i = 1'b0;
      checkOutput("ack_count", 32'(ackCnt), 1);
      checkOutput("ack_cycle", 32'(ackCyc), 0);
      checkOutput("complete_count", 32'(compCnt), 1);
      checkOutput("latency", 32'(compCyc - ackCyc), 32'(expLat));
      checkOutput("req_valid_cycles", 32'(vCnt), 32'(rdyDly + 1));
      checkOutput("wb_valid_cycles", 32'(wCnt), isStore ? 0 : 32'(wbDly + 1));
      checkOutput("timeout_pulses", 32'(toCnt), 0);
   endtask

   // Load with memory always ready and writeback never ready; flush and response at fixed cycles.
   task automatic flushTxn(input string name, input int flushCyc, input int respCyc, input int expComp);
      int compCnt = 0, compCyc = -1, lateValid = 0, wbSeen = 0;
      setRequest(1'b0, $urandom, $urandom, ROB_IDX_W'($urandom));
      for (int cyc = 0; cyc < 40; cyc++) begin
         applyStimulus(cyc == 0, cyc == flushCyc, 1'b1, cyc == respCyc, 1'b0);
         mem_resp_rdata_i = $urandom;
         @(negedge clk_i);
         if (cyc == 0) checkOutput($sformatf("%s_ack", name), 32'(repair_ack_o), 1);
         if (cyc > flushCyc && mem_req_valid_o) lateValid++;
         if (wb_valid_o) wbSeen++;
         if (repair_complete_o) begin
            compCnt++;
            if (compCyc < 0) compCyc = cyc;
         end
         nextCycle();
         if (compCyc >= 0 && cyc >= compCyc + 2) break;
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("%s_complete_count", name), 32'(compCnt), 1);
      checkOutput($sformatf("%s_complete_cycle", name), 32'(compCyc), 32'(expComp));
      checkOutput($sformatf("%s_late_req_valid", name), 32'(lateValid), 0);
      checkOutput($sformatf("%s_wb_valid", name), 32'(wbSeen), 0);
   endtask

   initial begin
      int toCnt, toCyc, compCnt, compCyc, wbCnt, busyLate;
      rst_ni = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      setRequest(1'b0, 32'h0, 32'h0, '0);
      mem_resp_rdata_i = 32'h0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      checkOutput("reset_ctrl", 32'({repair_ack_o, repair_complete_o, mem_req_valid_o, mem_req_we_o,
                                     wb_valid_o, busy_o, timeout_o}), 0);
      checkOutput("reset_data", mem_req_addr_o | mem_req_wdata_o | wb_data_o | 32'(wb_rob_idx_o), 0);
      repair_req_i = 1'b0;
      rst_ni       = 1'b1;
      nextCycle();
      nextCycle();

      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk_i);
      checkOutput("flush_idle_ack", 32'(repair_ack_o), 0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk_i);
      checkOutput("flush_idle_busy", 32'(busy_o), 0);
      nextCycle();

      runTxn(1'b0, 32'h0000_1000, $urandom, ROB_IDX_W'(5), 32'hDEAD_BEEF, 0, 0, 0, 1'b0);
      runTxn(1'b1, 32'h0000_2004, 32'h1234_5678, ROB_IDX_W'($urandom), $urandom, 3, 0, 0, 1'b0);
      runTxn(1'b0, 32'h0000_3000, $urandom, ROB_IDX_W'(7), 32'h1111_2222, 1, 1, 1, 1'b1);
      runTxn(1'b0, 32'h0000_3040, $urandom, ROB_IDX_W'(8), 32'h3333_4444, 0, 2, 0, 1'b0);

      flushTxn("flush_issue", 1, -1, 3);
      flushTxn("flush_wait_drain", 2, 6, 8);
      flushTxn("flush_wait_resp", 2, 2, 4);
      flushTxn("flush_writeback", 3, 2, 5);

      for (int i = 0; i < 20; i++) begin
         runTxn(1'($urandom_range(0, 1)), $urandom, $urandom, ROB_IDX_W'($urandom), $urandom,
                $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3), 1'b0);
      end

      setRequest(1'b0, 32'h0000_5000, 32'h0, ROB_IDX_W'(9));
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      mem_resp_rdata_i = 32'hA5A5_0F0F;
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk_i);
      checkOutput("rst_pre_wb_valid", 32'(wb_valid_o), 1);
      checkOutput("rst_pre_wb_data", wb_data_o, 32'hA5A5_0F0F);
      repair_req_i = 1'b1;
      #2 rst_ni = 1'b0;
      #1;
      checkOutput("rst_mid_ctrl", 32'({repair_ack_o, repair_complete_o, mem_req_valid_o, mem_req_we_o,
                                       wb_valid_o, busy_o, timeout_o}), 0);
      checkOutput("rst_mid_data", mem_req_addr_o | mem_req_wdata_o | wb_data_o | 32'(wb_rob_idx_o), 0);
      repair_req_i = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      nextCycle();
      compCnt  = 0;
      busyLate = 0;
      for (int cyc = 0; cyc < 4; cyc++) begin
         @(negedge clk_i);
         if (repair_complete_o) compCnt++;
         if (busy_o) busyLate++;
         nextCycle();
      end
      checkOutput("rst_release_complete", 32'(compCnt), 0);
      checkOutput("rst_release_busy", 32'(busyLate), 0);

      toCnt = 0; toCyc = -1; compCnt = 0; compCyc = -1; wbCnt = 0; busyLate = 0;
      setRequest(1'b0, 32'h0000_6000, 32'h0, ROB_IDX_W'(3));
`ifdef MSHR_REPAIR_TIMEOUT_EN
      for (int cyc = 0; cyc < 24; cyc++) begin
         applyStimulus(cyc == 0, 1'b0, 1'b1, cyc == 14, 1'b1);
         mem_resp_rdata_i = 32'hBAD0_BAD0;
         @(negedge clk_i);
         if (timeout_o) begin
            toCnt++;
            toCyc = cyc;
         end
         if (repair_complete_o) begin
            compCnt++;
            compCyc = cyc;
         end
         if (wb_valid_o) wbCnt++;
         if (cyc >= 12 && busy_o) busyLate++;
         nextCycle();
      end
      checkOutput("timeout_pulses", 32'(toCnt), 1);
      checkOutput("timeout_cycle", 32'(toCyc), 10);
      checkOutput("timeout_complete_count", 32'(compCnt), 1);
      checkOutput("timeout_complete_cycle", 32'(compCyc), 11);
      checkOutput("timeout_wb_valid", 32'(wbCnt), 0);
      checkOutput("timeout_late_resp_busy", 32'(busyLate), 0);
`else
      for (int cyc = 0; cyc < 36; cyc++) begin
         applyStimulus(cyc == 0, 1'b0, 1'b1, cyc == 30, 1'b1);
         mem_resp_rdata_i = 32'hBAD0_BAD0;
         @(negedge clk_i);
         if (cyc == 29) checkOutput("no_timeout_still_busy", 32'(busy_o), 1);
         if (timeout_o) toCnt++;
         if (repair_complete_o) begin
            compCnt++;
            compCyc = cyc;
         end
         if (wb_valid_o) begin
            wbCnt++;
            checkOutput("no_timeout_wb_data", wb_data_o, 32'hBAD0_BAD0);
         end
         nextCycle();
      end
      checkOutput("no_timeout_pulses", 32'(toCnt), 0);
      checkOutput("no_timeout_complete_count", 32'(compCnt), 1);
      checkOutput("no_timeout_complete_cycle", 32'(compCyc), 33);
      checkOutput("no_timeout_wb_cycles", 32'(wbCnt), 1);
`endif
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      nextCycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
